// File: rtl/rotate_frame_sched.sv
// rotate_frame_sched: triple-buffer scheduler handing out write/read region bases for the rotation frame store
module rotate_frame_sched #(
    parameter int BUFSIZE = 76800,
    parameter int AW      = 18,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_vblank,
    input  logic          wr_we,
    input  logic          rd_frame_start,
    output logic [AW-1:0] wr_base,
    output logic [AW-1:0] rd_base,
    output logic [1:0]    wr_buf,
    output logic [1:0]    rd_buf,
    output logic          rd_valid,
    output logic [CW-1:0] drop_cnt,
    output logic [CW-1:0] repeat_cnt
);
    localparam logic [AW-1:0] BASE1 = AW'(BUFSIZE);
    localparam logic [AW-1:0] BASE2 = AW'(2 * BUFSIZE);
    localparam logic [CW-1:0] CMAX  = '1;

    logic [1:0]    w_q, l_q, r_q, w_d, l_d, r_d;
    logic          fresh_q, fresh_d, wrote_q, wrote_d, old_vb_q, rd_valid_q, rd_valid_d;
    logic [CW-1:0] drop_q, drop_d, rep_q, rep_d;
    logic [AW-1:0] wr_base_q, rd_base_q;
    logic          vb_rise, complete, start, both, take, drop_inc, rep_inc;

    // Region index to base address as a three-way constant mux, no multiplier
    function automatic logic [AW-1:0] base_of(input logic [1:0] idx);
        return idx == 2'd0 ? '0 : idx == 2'd1 ? BASE1 : BASE2;
    endfunction

    assign vb_rise  = wr_vblank & ~old_vb_q;
    assign complete = vb_rise & (wrote_q | wr_we);
    assign start    = rd_frame_start & rd_valid_q;
    // Reader grabs the frame finishing this very cycle; the older latest frame is dropped
    assign both     = complete & start;
    assign take     = start & ~complete & fresh_q;
    assign drop_inc = complete & fresh_q;
    assign rep_inc  = start & ~complete & ~fresh_q;

    // Next-state rotation of the three region indices and bookkeeping
    always_comb begin
        w_d        = both ? r_q : complete ? l_q : w_q;
        l_d        = both ? l_q : complete ? w_q : take ? r_q : l_q;
        r_d        = both ? w_q : take ? l_q : r_q;
        fresh_d    = complete ? ~start : take ? 1'b0 : fresh_q;
        wrote_d    = vb_rise ? 1'b0 : (wrote_q | wr_we);
        rd_valid_d = rd_valid_q | complete;
        drop_d     = (drop_inc && drop_q != CMAX) ? drop_q + 1'b1 : drop_q;
        rep_d      = (rep_inc && rep_q != CMAX) ? rep_q + 1'b1 : rep_q;
    end

    // State registers; bases follow the indices one clock later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_q        <= 2'd0;
            l_q        <= 2'd1;
            r_q        <= 2'd2;
            fresh_q    <= 1'b0;
            wrote_q    <= 1'b0;
            old_vb_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            drop_q     <= '0;
            rep_q      <= '0;
            wr_base_q  <= '0;
            rd_base_q  <= BASE2;
        end else begin
            w_q        <= w_d;
            l_q        <= l_d;
            r_q        <= r_d;
            fresh_q    <= fresh_d;
            wrote_q    <= wrote_d;
            old_vb_q   <= wr_vblank;
            rd_valid_q <= rd_valid_d;
            drop_q     <= drop_d;
            rep_q      <= rep_d;
            wr_base_q  <= base_of(w_q);
            rd_base_q  <= base_of(r_q);
        end
    end

    assign wr_base    = wr_base_q;
    assign rd_base    = rd_base_q;
    assign wr_buf     = w_q;
    assign rd_buf     = r_q;
    assign rd_valid   = rd_valid_q;
    assign drop_cnt   = drop_q;
    assign repeat_cnt = rep_q;
endmodule

// File: tb/tb_rotate_frame_sched.sv
// tb_rotate_frame_sched: directed checks of the triple-buffer scheduler
module tb_rotate_frame_sched;
    localparam int BUFSIZE = 76800;
    localparam int AW      = 18;
    localparam int CW      = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_vblank = 1'b0;
    logic          wr_we = 1'b0;
    logic          rd_frame_start = 1'b0;
    logic [AW-1:0] wr_base, rd_base;
    logic [1:0]    wr_buf, rd_buf;
    logic          rd_valid;
    logic [CW-1:0] drop_cnt, repeat_cnt;
    int            n_cmp = 0;
    int            n_bad = 0;

    rotate_frame_sched #(.BUFSIZE(BUFSIZE), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .wr_vblank(wr_vblank), .wr_we(wr_we),
        .rd_frame_start(rd_frame_start), .wr_base(wr_base), .rd_base(rd_base),
        .wr_buf(wr_buf), .rd_buf(rd_buf), .rd_valid(rd_valid),
        .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Writer must never share a region with the reader
    always @(negedge clk) if (reset_n) chk("w_ne_r", 32'(wr_buf != rd_buf), 1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        wr_we = 0; wr_vblank = 0; rd_frame_start = 0;
        reset_n = 0;
        #3;
        reset_n = 1;
    endtask

    // One frame: optional pixel write, then a vblank rise with optional reader start
    task automatic frame(input bit we, input bit st);
        wr_we = we; rd_frame_start = 0;
        tick();
        wr_we = 0; wr_vblank = 1; rd_frame_start = st;
        tick();
        wr_vblank = 0; rd_frame_start = 0;
    endtask

    task automatic pulse();
        rd_frame_start = 1;
        tick();
        rd_frame_start = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wrbuf"}, 32'(wr_buf), 0);
        chk({tag, "_rdbuf"}, 32'(rd_buf), 2);
        chk({tag, "_wrbase"}, 32'(wr_base), 0);
        chk({tag, "_rdbase"}, 32'(rd_base), 153600);
        chk({tag, "_valid"}, 32'(rd_valid), 0);
        chk({tag, "_drop"}, 32'(drop_cnt), 0);
        chk({tag, "_rep"}, 32'(repeat_cnt), 0);
    endtask

    initial begin
        // 1: two written frames, no reader
        do_reset();
        chk_reset("rst");
        frame(1, 0);
        chk("t1_w1", 32'(wr_buf), 1);
        chk("t1_valid1", 32'(rd_valid), 1);
        chk("t1_drop1", 32'(drop_cnt), 0);
        tick();
        chk("t1_wrbase1", 32'(wr_base), 76800);
        frame(1, 0);
        chk("t1_w2", 32'(wr_buf), 0);
        chk("t1_drop2", 32'(drop_cnt), 1);
        pulse();
        chk("t1_fresh_rd", 32'(rd_buf), 1);
        chk("t1_rep", 32'(repeat_cnt), 0);

        // 2: reader start before anything is published
        do_reset();
        pulse();
        tick();
        chk("t2_rdbase", 32'(rd_base), 153600);
        chk("t2_rdbuf", 32'(rd_buf), 2);
        chk("t2_rep", 32'(repeat_cnt), 0);

        // 3: one frame then reader start, then a repeat
        do_reset();
        frame(1, 0);
        pulse();
        chk("t3_rdbuf", 32'(rd_buf), 0);
        chk("t3_rdbase_lag", 32'(rd_base), 153600);
        tick();
        chk("t3_rdbase", 32'(rd_base), 0);
        chk("t3_wrbuf", 32'(wr_buf), 1);
        pulse();
        chk("t3_rep", 32'(repeat_cnt), 1);
        chk("t3_rdbuf2", 32'(rd_buf), 0);

        // 4: W=1 L=2 R=0; publish frame (W=2 L=1 fresh), then coincident rise+start
        frame(1, 0);
        chk("t4_wpre", 32'(wr_buf), 2);
        chk("t4_droppre", 32'(drop_cnt), 0);
        frame(1, 1);
        chk("t4_rdbuf", 32'(rd_buf), 2);
        chk("t4_wrbuf", 32'(wr_buf), 0);
        chk("t4_drop", 32'(drop_cnt), 1);
        pulse();
        chk("t4_rep", 32'(repeat_cnt), 2);
        chk("t4_rdbuf2", 32'(rd_buf), 2);
        tick();
        chk("t4_rdbase", 32'(rd_base), 153600);
        chk("t4_wrbase", 32'(wr_base), 0);

        // 5: empty frame is not published; drop counter saturates
        do_reset();
        frame(0, 0);
        chk("t5_wrbuf", 32'(wr_buf), 0);
        chk("t5_rdbuf", 32'(rd_buf), 2);
        chk("t5_valid", 32'(rd_valid), 0);
        for (int i = 0; i < 301; i++) frame(1, 0);
        chk("t5_drop_sat", 32'(drop_cnt), 255);
        chk("t5_rep", 32'(repeat_cnt), 0);

        // 6: asynchronous reset mid-frame
        do_reset();
        frame(1, 0);
        wr_we = 1;
        tick();
        reset_n = 0;
        #1;
        chk_reset("t6_async");
        #2;
        reset_n = 1;
        wr_we = 0;
        frame(0, 0);
        chk("t6_novalid", 32'(rd_valid), 0);
        chk("t6_w_hold", 32'(wr_buf), 0);
        frame(1, 0);
        chk("t6_w", 32'(wr_buf), 1);
        chk("t6_valid", 32'(rd_valid), 1);
        chk("t6_drop", 32'(drop_cnt), 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
